text_write_ctrl: RTL and testbench
==================================

# text_write_ctrl

Sequencer and arbiter for the write port of the 40x20 text tile RAM. It accepts 7-bit character codes from two independent requesters, for example the local switch/button path and a UART receiver, and grants them round-robin. It interprets printable characters and control codes, maintains the cursor, and drives the RAM write port (`we`, `addr_w`, `din`). The display path reads `cur_x`/`cur_y` for cursor highlighting.

## Interface
- `MAX_X`, 40, columns per screen
- `MAX_Y`, 20, rows per screen
- `clk` input 1: system clock; all state on rising edge
- `reset` input 1: asynchronous, active-low (0 = reset)
- `a_valid` input 1: requester A has a code
- `a_data` input 7: requester A code
- `a_ready` output 1: A's code is consumed this cycle
- `b_valid` input 1: requester B has a code
- `b_data` input 7: requester B code
- `b_ready` output 1: B's code is consumed this cycle
- `we` output 1: tile RAM write enable, registered
- `addr_w` output 12: `{row[4:0], col[6:0]}`, registered
- `din` output 7: character to write, registered
- `cur_x` output 7: cursor column, 0..MAX_X-1
- `cur_y` output 5: cursor row, 0..MAX_Y-1
- `busy` output 1: clear sweep in progress

## Operation
- Reset values: `we`=0, `addr_w`=0, `din`=0, `cur_x`=0, `cur_y`=0, `busy`=0, state IDLE, round-robin pointer favours A.
- While `reset`=0, `a_ready` and `b_ready` are 0.
- States: IDLE and CLEAR.
- In IDLE, at most one code is accepted per cycle.
  - `a_ready` and `b_ready` are combinational and never high together.
  - If only one valid is high, that requester gets ready.
  - If both are high, the requester not served last gets ready.
  - The pointer updates only on a completed transfer (`valid`&`ready`).
- In CLEAR, both readies are 0. Requester data must be held stable until its ready is seen.
- Code handling, on acceptance:
  - 0x20–0x7E (printable): write the code at the current cursor, then advance the cursor.
    - Advance rule: x+1. At x=MAX_X-1, set x=0 and y+1. At y=MAX_Y-1, y wraps to 0.
  - 0x0A or 0x0D: set x=0, y+1 with the same wrap. No write.
  - 0x08 (backspace): move the cursor back one cell, then write 0x20 at the new cursor.
    - Backspace move: if x>0, x-1. Else if y>0, x=MAX_X-1 and y-1. At (0,0), stay at (0,0).
  - 0x0C: set the cursor to (0,0) and enter CLEAR.
  - Any other code (0x00–0x1F not listed above, 0x7F): consumed with no write and no cursor change.
- CLEAR sweep:
  - Writes 0x20 to all MAX_X*MAX_Y cells, row-major, one cell per cycle, starting at (0,0).
  - Uses internal sweep counters and does not modify the cursor.
  - Returns to IDLE after cell (MAX_Y-1, MAX_X-1).
- `busy` = 1 exactly while in CLEAR.
- When reset asserts mid-sweep, the sweep aborts immediately and all outputs return to their reset values. Cells not yet written keep their old contents.

## Timing
- Acceptance at edge k. During cycle k+1:
  - `we`=1 (for writing codes).
  - `addr_w`/`din` hold the target cell and character.
  - `cur_x`/`cur_y` already show the updated cursor.
- For printable codes, `addr_w` is the pre-advance cursor. For backspace, it is the post-retreat cursor.
- Non-writing codes leave `we`=0 in cycle k+1.
- Back-to-back printable codes from one or both requesters produce one write per cycle. Maximum throughput is 1 code/cycle.
- 0x0C accepted at edge k:
  - Cycles k+1 through k+MAX_X*MAX_Y (k+800 by default) carry `we`=1, `busy`=1, with addresses sweeping from `{0,0}` to `{19,39}`.
  - In cycle k+801, `we`=0, `busy`=0, and state is IDLE; a ready may be asserted in that cycle.
- Address packing: row occupies bits [11:7] and column bits [6:0]. Columns 40–127 are never addressed.

## Structure
- Shared package `text_pkg`:
  - `MAX_X`, `MAX_Y` defaults.
  - ASCII constants `CH_BS`=0x08, `CH_LF`=0x0A, `CH_FF`=0x0C, `CH_CR`=0x0D, `CH_SP`=0x20.
  - State enum {IDLE, CLEAR}.
  - Address-pack function `{row, col}`.
- One sub-module, `rr_arbiter2`:
  - Two-requester round-robin.
  - Inputs: `req[1:0]`, `enable`, transfer-done.
  - Outputs: one-hot `grant[1:0]`; holds the last-served pointer.
- Everything else (code decode, cursor arithmetic, sweep counters, output registers) lives in `text_write_ctrl`.

## Test plan
- Reset release, A sends 'H'(0x48) then 'i'(0x69) back-to-back:
  - `we` high for two consecutive cycles.
  - `addr_w`=0x000 with `din`=0x48, then `addr_w`=0x001 with `din`=0x69.
  - Cursor ends at (1,0) then (2,0).
- Both valid every cycle, A=0x41 and B=0x42, for 4 transfers:
  - Grants go A,B,A,B.
  - Writes land at cols 0–3 with data 41,42,41,42.
- Cursor at (39,19), printable 0x5A:
  - Write at `addr_w`={19,39}=0x9A7.
  - Cursor wraps to (0,0).
- Cursor at (0,1), 0x08:
  - Cursor becomes (39,0).
  - Write 0x20 at 0x027.
- Cursor at (0,0), 0x08:
  - Cursor stays at (0,0).
  - Write 0x20 at 0x000.
- 0x0C accepted:
  - Exactly 800 writes of 0x20, first 0x000, last 0x9A7.
  - `busy`=1 and both readies 0 throughout, even with `a_valid`=1.
  - Cursor is (0,0).
  - Reset pulsed at write 300 → `we`=0 and state IDLE immediately.

Source files
------------

// File: rtl/text_pkg.sv
// Shared definitions for the text tile RAM writer.
// Screen geometry, ASCII codes, FSM states, address packing.
package text_pkg;

  localparam int DEF_MAX_X = 40;
  localparam int DEF_MAX_Y = 20;

  localparam logic [6:0] CH_BS = 7'h08;
  localparam logic [6:0] CH_LF = 7'h0A;
  localparam logic [6:0] CH_FF = 7'h0C;
  localparam logic [6:0] CH_CR = 7'h0D;
  localparam logic [6:0] CH_SP = 7'h20;
  localparam logic [6:0] CH_TL = 7'h7E;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  function automatic logic [11:0] pack_addr(
    input logic [4:0] row,
    input logic [6:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/text_write_ctrl_if.sv
// Two-requester code handshake bundle.
// master = requester side, slave = writer side.
interface text_write_ctrl_if;

  logic       a_valid;
  logic [6:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [6:0] b_data;
  logic       b_ready;

  modport master (
    output a_valid, a_data,
    output b_valid, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_data,
    input  b_valid, b_data,
    output a_ready, b_ready
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// last_b remembers who was served last; reset favours A.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       done,
  output logic [1:0] grant
);

  logic last_b;

  // one-hot grant, the side not served last wins a tie
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_b ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // pointer moves only on a completed transfer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_b <= 1'b1;
    end else if (done) begin
      last_b <= grant[1];
    end
  end

endmodule

// File: rtl/text_write_ctrl.sv
// Write-port sequencer for the text tile RAM.
// Arbitrates two code sources, tracks cursor, runs clear sweep.
module text_write_ctrl
  import text_pkg::*;
#(
  parameter int MAX_X = DEF_MAX_X,
  parameter int MAX_Y = DEF_MAX_Y
) (
  input  logic               clk,
  input  logic               reset,
  text_write_ctrl_if.slave   req,
  output logic               we,
  output logic [11:0]        addr_w,
  output logic [6:0]         din,
  output logic [6:0]         cur_x,
  output logic [4:0]         cur_y,
  output logic               busy
);

  localparam logic [6:0] X_LAST = 7'(MAX_X - 1);
  localparam logic [4:0] Y_LAST = 5'(MAX_Y - 1);

  state_t      state_q, state_d;
  logic [1:0]  grant;
  logic        acc;
  logic [6:0]  code;
  logic [6:0]  sx, sx_d;
  logic [4:0]  sy, sy_d;
  logic        sweep_last;
  logic        we_d;
  logic [11:0] addr_d;
  logic [6:0]  din_d;
  logic [6:0]  x_d;
  logic [4:0]  y_d;
  logic        x_end, y_end;
  logic [6:0]  adv_x, bs_x;
  logic [4:0]  adv_y, nl_y, bs_y;
  logic        is_print, is_nl;
  logic        is_bs, is_ff;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({req.b_valid, req.a_valid}),
    .enable (reset && (state_q == IDLE)),
    .done   (acc),
    .grant  (grant)
  );

  assign req.a_ready = grant[0];
  assign req.b_ready = grant[1];
  assign acc  = |(grant & {req.b_valid, req.a_valid});
  assign code = grant[1] ? req.b_data : req.a_data;
  assign busy = (state_q == CLEAR);

  assign sweep_last = (sx == X_LAST) && (sy == Y_LAST);

  assign is_print = (code >= CH_SP) && (code <= CH_TL);
  assign is_nl    = (code == CH_LF) || (code == CH_CR);
  assign is_bs    = (code == CH_BS);
  assign is_ff    = (code == CH_FF);

  // cursor neighbours: forward, newline and backspace targets
  always_comb begin
    x_end = (cur_x == X_LAST);
    y_end = (cur_y == Y_LAST);
    nl_y  = y_end ? 5'd0 : cur_y + 5'd1;
    adv_x = x_end ? 7'd0 : cur_x + 7'd1;
    adv_y = x_end ? nl_y : cur_y;
    bs_x  = cur_x;
    bs_y  = cur_y;
    if (cur_x != 7'd0) begin
      bs_x = cur_x - 7'd1;
    end else if (cur_y != 5'd0) begin
      bs_x = X_LAST;
      bs_y = cur_y - 5'd1;
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: form feed starts a sweep, last cell ends it
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (acc && is_ff) state_d = CLEAR;
      CLEAR:   if (sweep_last)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // next values of the write port, cursor and sweep counters
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_w;
    din_d  = din;
    x_d    = cur_x;
    y_d    = cur_y;
    sx_d   = sx;
    sy_d   = sy;
    if (state_q == CLEAR) begin
      if (!sweep_last) begin
        sx_d   = (sx == X_LAST) ? 7'd0 : sx + 7'd1;
        sy_d   = (sx == X_LAST) ? sy + 5'd1 : sy;
        we_d   = 1'b1;
        addr_d = pack_addr(sy_d, sx_d);
        din_d  = CH_SP;
      end
    end else if (acc) begin
      unique case (1'b1)
        is_print: begin
          we_d   = 1'b1;
          addr_d = pack_addr(cur_y, cur_x);
          din_d  = code;
          x_d    = adv_x;
          y_d    = adv_y;
        end
        is_nl: begin
          x_d = 7'd0;
          y_d = nl_y;
        end
        is_bs: begin
          we_d   = 1'b1;
          addr_d = pack_addr(bs_y, bs_x);
          din_d  = CH_SP;
          x_d    = bs_x;
          y_d    = bs_y;
        end
        is_ff: begin
          we_d   = 1'b1;
          addr_d = pack_addr(5'd0, 7'd0);
          din_d  = CH_SP;
          x_d    = 7'd0;
          y_d    = 5'd0;
          sx_d   = 7'd0;
          sy_d   = 5'd0;
        end
        default: ;
      endcase
    end
  end

  // registered write port, cursor and sweep position
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we     <= 1'b0;
      addr_w <= '0;
      din    <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
      sx     <= '0;
      sy     <= '0;
    end else begin
      we     <= we_d;
      addr_w <= addr_d;
      din    <= din_d;
      cur_x  <= x_d;
      cur_y  <= y_d;
      sx     <= sx_d;
      sy     <= sy_d;
    end
  end

endmodule

// File: tb/tb_text_write_ctrl.sv
// Randomized bench for text_write_ctrl.
// Screen-level cursor/write model checked every cycle.
module tb_text_write_ctrl;

  logic        clk;
  logic        reset;
  logic        we;
  logic [11:0] addr_w;
  logic [6:0]  din;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        busy;

  text_write_ctrl_if rq ();

  text_write_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .req    (rq),
    .we     (we),
    .addr_w (addr_w),
    .din    (din),
    .cur_x  (cur_x),
    .cur_y  (cur_y),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  int a_q[$];
  int b_q[$];
  bit a_on, b_on;
  int gap_pct;

  int mx, my;
  bit m_last_b;
  bit m_busy;
  int m_idx;
  bit exp_we;
  int exp_addr;
  int exp_din;
  int n_sweep_wr;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx       = 0;
    my       = 0;
    m_last_b = 1'b1;
    m_busy   = 1'b0;
    m_idx    = 0;
    exp_we   = 1'b0;
    exp_addr = 0;
    exp_din  = 0;
  endtask

  task automatic accept(input int c);
    if (c >= 32 && c <= 126) begin
      exp_we   = 1'b1;
      exp_addr = my * 128 + mx;
      exp_din  = c;
      mx++;
      if (mx == 40) begin
        mx = 0;
        my = (my + 1) % 20;
      end
    end else if (c == 10 || c == 13) begin
      exp_we = 1'b0;
      mx     = 0;
      my     = (my + 1) % 20;
    end else if (c == 8) begin
      if (mx > 0) mx--;
      else if (my > 0) begin
        mx = 39;
        my--;
      end
      exp_we   = 1'b1;
      exp_addr = my * 128 + mx;
      exp_din  = 32;
    end else if (c == 12) begin
      mx       = 0;
      my       = 0;
      m_busy   = 1'b1;
      m_idx    = 0;
      exp_we   = 1'b1;
      exp_addr = 0;
      exp_din  = 32;
    end else begin
      exp_we = 1'b0;
    end
  endtask

  task automatic drive();
    if (!a_on && a_q.size() > 0 &&
        $urandom_range(99) < gap_pct) a_on = 1'b1;
    if (!b_on && b_q.size() > 0 &&
        $urandom_range(99) < gap_pct) b_on = 1'b1;
    rq.a_valid = a_on;
    rq.b_valid = b_on;
    rq.a_data  = a_on ? 7'(a_q[0]) : 7'($urandom);
    rq.b_data  = b_on ? 7'(b_q[0]) : 7'($urandom);
  endtask

  task automatic run_cycle();
    bit ga, gb;
    drive();
    @(negedge clk);
    ga = 1'b0;
    gb = 1'b0;
    if (!m_busy) begin
      if (a_on && b_on) begin
        if (m_last_b) ga = 1'b1;
        else gb = 1'b1;
      end else begin
        ga = a_on;
        gb = b_on;
      end
    end
    chk("we", 32'(we), 32'(exp_we));
    if (exp_we) begin
      chk("addr_w", 32'(addr_w), exp_addr);
      chk("din", 32'(din), exp_din);
    end
    chk("cur_x", 32'(cur_x), mx);
    chk("cur_y", 32'(cur_y), my);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("a_ready", 32'(rq.a_ready), 32'(ga));
    chk("b_ready", 32'(rq.b_ready), 32'(gb));
    if (we && busy) n_sweep_wr++;
    if (m_busy) begin
      if (m_idx == 799) begin
        m_busy = 1'b0;
        exp_we = 1'b0;
      end else begin
        m_idx++;
        exp_addr = (m_idx / 40) * 128 + (m_idx % 40);
      end
    end else if (ga) begin
      accept(a_q[0]);
    end else if (gb) begin
      accept(b_q[0]);
    end else begin
      exp_we = 1'b0;
    end
    if (ga) begin
      m_last_b = 1'b0;
      void'(a_q.pop_front());
      a_on = 1'b0;
    end
    if (gb) begin
      m_last_b = 1'b1;
      void'(b_q.pop_front());
      b_on = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while ((a_q.size() > 0 || b_q.size() > 0 || m_busy) &&
           n < budget) begin
      run_cycle();
      n++;
    end
    chk("drain_left",
        32'(a_q.size() + b_q.size() + int'(m_busy)), 0);
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    rq.a_valid = 1'b1;
    rq.b_valid = 1'b1;
    #1;
    chk("rst_we", 32'(we), 0);
    chk("rst_addr", 32'(addr_w), 0);
    chk("rst_din", 32'(din), 0);
    chk("rst_cur_x", 32'(cur_x), 0);
    chk("rst_cur_y", 32'(cur_y), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_a_ready", 32'(rq.a_ready), 0);
    chk("rst_b_ready", 32'(rq.b_ready), 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_we", 32'(we), 0);
    reset = 1'b1;
  endtask

  function automatic int rand_code();
    int r;
    r = $urandom_range(99);
    if (r < 70) return $urandom_range(126, 32);
    if (r < 78) return (r < 74) ? 10 : 13;
    if (r < 90) return 8;
    case (r % 5)
      0: return 0;
      1: return 27;
      2: return 127;
      3: return 1;
      default: return 9;
    endcase
  endfunction

  initial begin
    n_vec      = 0;
    n_err      = 0;
    n_sweep_wr = 0;
    a_on       = 1'b0;
    b_on       = 1'b0;
    gap_pct    = 100;
    reset      = 1'b0;
    rq.a_valid = 1'b0;
    rq.b_valid = 1'b0;
    rq.a_data  = '0;
    rq.b_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    a_q.push_back(8'h48);
    a_q.push_back(8'h69);
    run_drain(20);
    chk("hi_cur_x", 32'(cur_x), 2);

    do_reset();
    a_q.push_back(8'h41);
    a_q.push_back(8'h41);
    b_q.push_back(8'h42);
    b_q.push_back(8'h42);
    run_drain(20);

    do_reset();
    repeat (19) a_q.push_back(10);
    repeat (39) a_q.push_back(8'h61);
    a_q.push_back(8'h5A);
    run_drain(200);
    chk("wrap_cur", 32'({cur_y, cur_x}), 0);
    a_q.push_back(10);
    a_q.push_back(8);
    run_drain(20);
    chk("bs_row_up", 32'({cur_y, cur_x}), 39);

    do_reset();
    a_q.push_back(8);
    run_drain(20);

    gap_pct = 50;
    for (int i = 0; i < 800; i++) begin
      a_q.push_back(rand_code());
      b_q.push_back(rand_code());
    end
    run_drain(8000);

    gap_pct = 100;
    a_q.push_back(8'h55);
    a_q.push_back(12);
    repeat (3) a_q.push_back(8'h41);
    repeat (3) b_q.push_back(8'h42);
    n_sweep_wr = 0;
    run_drain(1000);
    chk("sweep_writes", n_sweep_wr, 800);

    a_q.push_back(12);
    repeat (4) a_q.push_back(8'h43);
    n_sweep_wr = 0;
    for (int n = 0; n < 400 && !(m_busy && m_idx == 300); n++)
      run_cycle();
    chk("mid_busy", 32'(m_busy && m_idx == 300), 1);
    chk("mid_count", n_sweep_wr, 300);
    do_reset();
    run_drain(100);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
